// File: rtl/spi_bus_scheduler_pkg.sv
// Shared types and constants for the round-robin SPI bus scheduler.
package spi_bus_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_t;

  // Mode 0: sclk rests low between transfers
  localparam logic SCLK_IDLE = 1'b0;

  // Width of a slave-select index; a single slave still needs one bit
  function automatic int sel_width(input int num_ss);
    return (num_ss > 1) ? $clog2(num_ss) : 1;
  endfunction

endpackage

// File: rtl/spi_bus_scheduler_rr_arbiter.sv
// Round-robin pick of the first active request at or after the rotation pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [NUM_REQ-1:0] owner,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] owner_idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner[i]) owner_idx = PW'(i);
    end
  end

  // The requester just served drops to lowest priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (owner_idx == PW'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;
    end
  end

endmodule

// File: rtl/spi_bus_scheduler.sv
// SPI mode-0 master shared round-robin between NUM_REQ requesters;
// one full-duplex byte per grant, received byte returned with a done pulse.
module spi_bus_scheduler
  import spi_bus_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_SS  = 4,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ*8-1:0]                  req_data,
  input  logic [NUM_REQ*sel_width(NUM_SS)-1:0]  req_sel,
  output logic [NUM_REQ-1:0]                    grant,
  output logic                                  done,
  output logic [7:0]                            rx_data,
  output logic                                  busy,
  output logic                                  sclk,
  output logic [NUM_SS-1:0]                     ss,
  output logic                                  mosi,
  input  logic                                  miso
);

  localparam int SSW     = sel_width(NUM_SS);
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX);

  state_t             state, next_state;
  logic [CW-1:0]      cnt, cnt_limit;
  logic               cnt_last;
  logic [2:0]         bit_cnt;
  logic [7:0]         tx_sh, rx_sh;
  logic [NUM_REQ-1:0] pick;
  logic [7:0]         win_data;
  logic [SSW-1:0]     win_sel;
  logic [NUM_SS-1:0]  win_ss;
  logic               advance;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .owner   (grant),
    .grant   (pick)
  );

  // One timer serves every phase; only GAP uses a different length
  assign cnt_limit = (state == GAP) ? CW'(CS_GAP - 1) : CW'(CLK_DIV - 1);
  assign cnt_last  = (cnt == cnt_limit);
  assign advance   = (state == HOLD) && cnt_last;

  always_comb begin
    win_data = '0;
    win_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        win_data = req_data[8*i +: 8];
        win_sel  = req_sel[SSW*i +: SSW];
      end
    end
    win_ss = '1;
    for (int k = 0; k < NUM_SS; k++) begin
      if (win_sel == SSW'(k)) win_ss[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (|pick)   next_state = SETUP;
      SETUP:    if (cnt_last) next_state = SHIFT_HI;
      SHIFT_HI: if (cnt_last) next_state = SHIFT_LO;
      SHIFT_LO: if (cnt_last) next_state = (bit_cnt == 3'd7) ? HOLD : SHIFT_HI;
      HOLD:     if (cnt_last) next_state = GAP;
      GAP:      if (cnt_last) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Falling sclk edges both capture miso and present the next mosi bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      grant   <= '0;
      done    <= 1'b0;
      rx_data <= '0;
      busy    <= 1'b0;
      sclk    <= SCLK_IDLE;
      ss      <= '1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt_last ? '0 : cnt + 1'b1;

      unique case (state)
        IDLE: if (|pick) begin
          grant   <= pick;
          busy    <= 1'b1;
          tx_sh   <= win_data;
          ss      <= win_ss;
          mosi    <= win_data[7];
          bit_cnt <= '0;
        end
        SETUP: if (cnt_last) sclk <= ~SCLK_IDLE;
        SHIFT_HI: if (cnt_last) begin
          sclk  <= SCLK_IDLE;
          rx_sh <= {rx_sh[6:0], miso};
          tx_sh <= {tx_sh[6:0], 1'b0};
          mosi  <= tx_sh[6];
        end
        SHIFT_LO: if (cnt_last && bit_cnt != 3'd7) begin
          sclk    <= ~SCLK_IDLE;
          bit_cnt <= bit_cnt + 3'd1;
        end
        HOLD: if (cnt_last) begin
          ss      <= '1;
          done    <= 1'b1;
          rx_data <= rx_sh;
          grant   <= '0;
        end
        GAP: if (cnt_last) busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// Self-checking bench: SPI slave model on the bus, transfer monitor, and a
// round-robin reference model predicting winners, bytes and timing.
module tb_spi_bus_scheduler;

  localparam int NUM_REQ = 4;
  localparam int NUM_SS  = 5;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;
  localparam int SSW     = 3;
  localparam int XFER    = 18 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [11:0] req_sel = '0;
  logic [3:0]  grant;
  logic        done;
  logic [7:0]  rx_data;
  logic        busy;
  logic        sclk;
  logic [4:0]  ss;
  logic        mosi;
  logic        miso;

  always #5 clk = ~clk;

  spi_bus_scheduler #(
    .NUM_REQ(NUM_REQ), .NUM_SS(NUM_SS), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_sel(req_sel),
    .grant(grant), .done(done), .rx_data(rx_data), .busy(busy), .sclk(sclk),
    .ss(ss), .mosi(mosi), .miso(miso)
  );

  int checks = 0;
  int passes = 0;
  int model_ptr = 0;
  int cyc = 0;
  int done_total = 0;
  logic [7:0] dat [4];
  int         sel [4];

  // Slave model: loads its reply when a grant appears, shifts on sclk edges
  logic [7:0] slave_byte = '0;
  logic [7:0] sl_tx = '0;
  logic [7:0] sl_rx = '0;
  int         sl_rises = 0;
  logic       any_grant;
  assign any_grant = |grant;
  assign miso = sl_tx[7];

  always @(posedge any_grant) begin
    sl_tx = slave_byte;
    sl_rx = '0;
    sl_rises = 0;
  end
  always @(posedge sclk) begin
    sl_rx = {sl_rx[6:0], mosi};
    sl_rises = sl_rises + 1;
  end
  always @(negedge sclk) sl_tx = {sl_tx[6:0], 1'b0};

  typedef struct packed {
    logic [3:0] winner;
    int         grant_cyc;
    int         done_cyc;
    int         ss_low;
    logic [4:0] ss_and;
    logic [7:0] rx;
    logic [7:0] sl_rx;
    int         rises;
  } rec_t;

  rec_t recs[$];
  rec_t cur = '0;
  bit   in_xfer = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      in_xfer = 1'b0;
    end else begin
      if (grant != 4'b0 && !in_xfer) begin
        in_xfer = 1'b1;
        cur = '0;
        cur.winner = grant;
        cur.grant_cyc = cyc;
        cur.ss_and = '1;
      end
      if (in_xfer) begin
        if (ss != 5'h1F) cur.ss_low = cur.ss_low + 1;
        cur.ss_and = cur.ss_and & ss;
      end
      if (done) begin
        done_total = done_total + 1;
        cur.done_cyc = cyc;
        cur.rx = rx_data;
        cur.sl_rx = sl_rx;
        cur.rises = sl_rises;
        recs.push_back(cur);
        in_xfer = 1'b0;
      end
    end
  end

  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [4:0] exp_ss(input int s);
    return (s < NUM_SS) ? ~(5'b00001 << s) : 5'b11111;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_requester(input int i, input logic [7:0] d, input int s);
    dat[i] = d;
    sel[i] = s;
    req_data[8*i +: 8] = d;
    req_sel[SSW*i +: SSW] = 3'(s);
  endtask

  task automatic wait_rec(output rec_t r, output bit ok);
    r = '0;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      if (recs.size() > 0) begin
        r = recs.pop_front();
        ok = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    model_ptr = 0;
    recs.delete();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (grant !== 4'b0) $display("[TB] FAIL reset_grant got %b exp 0000", grant); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b exp 0", done); else passes++;
    checks++; if (rx_data !== 8'h00) $display("[TB] FAIL reset_rx got %h exp 00", rx_data); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b exp 0", busy); else passes++;
    checks++; if (sclk !== 1'b0) $display("[TB] FAIL reset_sclk got %b exp 0", sclk); else passes++;
    checks++; if (ss !== 5'h1F) $display("[TB] FAIL reset_ss got %h exp 1f", ss); else passes++;
    checks++; if (mosi !== 1'b0) $display("[TB] FAIL reset_mosi got %b exp 0", mosi); else passes++;
    rst_n = 1'b1;
    model_ptr = 0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0 || grant !== 4'b0) $display("[TB] FAIL idle_quiet got busy=%b grant=%b exp 0/0000", busy, grant); else passes++;
  endtask

  task automatic test_single();
    rec_t r; bit ok; int e; int base;
    base = done_total;
    slave_byte = 8'h3C;
    set_requester(1, 8'hA5, 2);
    req[1] = 1'b1;
    e = rr_pick(4'b0010, model_ptr);
    wait_rec(r, ok);
    req[1] = 1'b0;
    model_ptr = (e + 1) % NUM_REQ;
    checks++; if (!ok) $display("[TB] FAIL single_timeout got no done exp done"); else passes++;
    checks++; if (r.winner !== 4'(1 << e)) $display("[TB] FAIL single_winner got %b exp %b", r.winner, 4'(1 << e)); else passes++;
    checks++; if (r.ss_low != XFER) $display("[TB] FAIL single_ss_low got %0d exp %0d", r.ss_low, XFER); else passes++;
    checks++; if (r.ss_and !== exp_ss(2)) $display("[TB] FAIL single_ss_sel got %b exp %b", r.ss_and, exp_ss(2)); else passes++;
    checks++; if (r.rx !== 8'h3C) $display("[TB] FAIL single_rx got %h exp 3c", r.rx); else passes++;
    checks++; if (r.sl_rx !== 8'hA5) $display("[TB] FAIL single_mosi got %h exp a5", r.sl_rx); else passes++;
    checks++; if (r.rises != 8) $display("[TB] FAIL single_edges got %0d exp 8", r.rises); else passes++;
    checks++; if (r.done_cyc - r.grant_cyc + 1 != XFER + 1) $display("[TB] FAIL single_latency got %0d exp %0d", r.done_cyc - r.grant_cyc + 1, XFER + 1); else passes++;
    repeat (20) tick();
    checks++; if (done_total - base != 1) $display("[TB] FAIL single_done_count got %0d exp 1", done_total - base); else passes++;
    checks++; if (rx_data !== 8'h3C) $display("[TB] FAIL single_rx_hold got %h exp 3c", rx_data); else passes++;
  endtask

  task automatic test_rotation();
    rec_t r; bit ok; int e; int prev_done;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_requester(i, 8'($urandom), $urandom_range(0, NUM_SS - 1));
    slave_byte = 8'($urandom);
    req = 4'hF;
    prev_done = 0;
    for (int n = 0; n < 5; n++) begin
      logic [7:0] sb;
      sb = slave_byte;
      e = rr_pick(4'hF, model_ptr);
      wait_rec(r, ok);
      if (n == 4) req = '0;
      slave_byte = 8'($urandom);
      model_ptr = (e + 1) % NUM_REQ;
      checks++; if (!ok) $display("[TB] FAIL rot_timeout_%0d got no done exp done", n); else passes++;
      checks++; if (r.winner !== 4'(1 << e)) $display("[TB] FAIL rot_winner_%0d got %b exp %b", n, r.winner, 4'(1 << e)); else passes++;
      checks++; if (r.rx !== sb) $display("[TB] FAIL rot_rx_%0d got %h exp %h", n, r.rx, sb); else passes++;
      checks++; if (r.sl_rx !== dat[e]) $display("[TB] FAIL rot_mosi_%0d got %h exp %h", n, r.sl_rx, dat[e]); else passes++;
      checks++; if (r.ss_and !== exp_ss(sel[e])) $display("[TB] FAIL rot_ss_%0d got %b exp %b", n, r.ss_and, exp_ss(sel[e])); else passes++;
      if (n > 0) begin
        checks++; if (r.grant_cyc - prev_done < CS_GAP) $display("[TB] FAIL rot_gap_%0d got %0d exp >=%0d", n, r.grant_cyc - prev_done, CS_GAP); else passes++;
      end
      prev_done = r.done_cyc;
    end
  endtask

  task automatic test_back_to_back();
    rec_t r1, r2; bit ok1, ok2; int e; int low; bit seen_high;
    set_requester(3, 8'($urandom), $urandom_range(0, NUM_SS - 1));
    slave_byte = 8'($urandom);
    req[3] = 1'b1;
    e = rr_pick(4'b1000, model_ptr);
    wait_rec(r1, ok1);
    model_ptr = (e + 1) % NUM_REQ;
    low = 0;
    seen_high = 1'b0;
    for (int k = 0; k < 30 && !seen_high; k++) begin
      tick();
      if (busy === 1'b0) low++;
      else if (low > 0) seen_high = 1'b1;
    end
    e = rr_pick(4'b1000, model_ptr);
    wait_rec(r2, ok2);
    req[3] = 1'b0;
    model_ptr = (e + 1) % NUM_REQ;
    checks++; if (!ok1 || !ok2) $display("[TB] FAIL b2b_timeout got %b%b exp 11", ok1, ok2); else passes++;
    checks++; if (r1.winner !== 4'b1000 || r2.winner !== 4'b1000) $display("[TB] FAIL b2b_winner got %b/%b exp 1000/1000", r1.winner, r2.winner); else passes++;
    checks++; if (low != 1) $display("[TB] FAIL b2b_busy_low got %0d exp 1", low); else passes++;
    checks++; if (r2.grant_cyc - r1.done_cyc != CS_GAP + 1) $display("[TB] FAIL b2b_regrant got %0d exp %0d", r2.grant_cyc - r1.done_cyc, CS_GAP + 1); else passes++;
    checks++; if (r2.sl_rx !== dat[3]) $display("[TB] FAIL b2b_mosi got %h exp %h", r2.sl_rx, dat[3]); else passes++;
  endtask

  task automatic test_reset_abort();
    rec_t r; bit ok; bit hit; int base;
    set_requester(0, 8'($urandom), 1);
    slave_byte = 8'($urandom);
    req[0] = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      tick();
      if (grant != 4'b0 && sl_rises >= 4) hit = 1'b1;
    end
    checks++; if (!hit) $display("[TB] FAIL abort_reach_bit4 got no 4th edge exp reached"); else passes++;
    base = done_total;
    rst_n = 1'b0;
    #1;
    checks++; if (ss !== 5'h1F) $display("[TB] FAIL abort_ss got %h exp 1f", ss); else passes++;
    checks++; if (sclk !== 1'b0) $display("[TB] FAIL abort_sclk got %b exp 0", sclk); else passes++;
    checks++; if (grant !== 4'b0) $display("[TB] FAIL abort_grant got %b exp 0000", grant); else passes++;
    repeat (3) tick();
    rst_n = 1'b1;
    model_ptr = 0;
    recs.delete();
    tick();
    checks++; if (done_total != base) $display("[TB] FAIL abort_no_done got %0d exp %0d", done_total, base); else passes++;
    wait_rec(r, ok);
    req[0] = 1'b0;
    model_ptr = 1;
    checks++; if (!ok || r.winner !== 4'b0001) $display("[TB] FAIL abort_restart got ok=%b winner=%b exp 1/0001", ok, r.winner); else passes++;
    checks++; if (r.ss_low != XFER) $display("[TB] FAIL abort_ss_low got %0d exp %0d", r.ss_low, XFER); else passes++;
    checks++; if (r.rx !== slave_byte) $display("[TB] FAIL abort_rx got %h exp %h", r.rx, slave_byte); else passes++;
  endtask

  task automatic test_bad_sel();
    rec_t r; bit ok; int e; int s;
    s = $urandom_range(NUM_SS, 7);
    set_requester(0, 8'($urandom), s);
    slave_byte = 8'($urandom);
    req[0] = 1'b1;
    e = rr_pick(4'b0001, model_ptr);
    wait_rec(r, ok);
    req[0] = 1'b0;
    model_ptr = (e + 1) % NUM_REQ;
    checks++; if (!ok) $display("[TB] FAIL badsel_timeout got no done exp done"); else passes++;
    checks++; if (r.ss_and !== 5'h1F || r.ss_low != 0) $display("[TB] FAIL badsel_ss got %b/%0d exp 11111/0", r.ss_and, r.ss_low); else passes++;
    checks++; if (r.rises != 8) $display("[TB] FAIL badsel_edges got %0d exp 8", r.rises); else passes++;
    checks++; if (r.rx !== slave_byte) $display("[TB] FAIL badsel_rx got %h exp %h", r.rx, slave_byte); else passes++;
  endtask

  task automatic test_drop_req();
    rec_t r; bit ok; int e; int regrants;
    set_requester(2, 8'($urandom), $urandom_range(0, NUM_SS - 1));
    slave_byte = 8'($urandom);
    req[2] = 1'b1;
    e = rr_pick(4'b0100, model_ptr);
    for (int k = 0; k < 50 && grant == 4'b0; k++) tick();
    req[2] = 1'b0;
    wait_rec(r, ok);
    model_ptr = (e + 1) % NUM_REQ;
    checks++; if (!ok || r.winner !== 4'b0100) $display("[TB] FAIL drop_done got ok=%b winner=%b exp 1/0100", ok, r.winner); else passes++;
    checks++; if (r.sl_rx !== dat[2]) $display("[TB] FAIL drop_mosi got %h exp %h", r.sl_rx, dat[2]); else passes++;
    regrants = 0;
    repeat (30) begin
      tick();
      if (grant != 4'b0) regrants++;
    end
    checks++; if (regrants != 0 || busy !== 1'b0) $display("[TB] FAIL drop_regrant got %0d busy=%b exp 0/0", regrants, busy); else passes++;
  endtask

  task automatic test_random();
    rec_t r; bit ok; int e; logic [3:0] pending;
    for (int round = 0; round < 6; round++) begin
      pending = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_REQ; i++) if (pending[i]) set_requester(i, 8'($urandom), $urandom_range(0, 7));
      slave_byte = 8'($urandom);
      req = pending;
      while (pending != 4'b0) begin
        logic [7:0] sb;
        sb = slave_byte;
        e = rr_pick(pending, model_ptr);
        wait_rec(r, ok);
        pending[e] = 1'b0;
        req[e] = 1'b0;
        model_ptr = (e + 1) % NUM_REQ;
        slave_byte = 8'($urandom);
        checks++; if (!ok || r.winner !== 4'(1 << e)) $display("[TB] FAIL rand_winner_%0d got %b exp %b", round, r.winner, 4'(1 << e)); else passes++;
        checks++; if (r.rx !== sb || r.sl_rx !== dat[e]) $display("[TB] FAIL rand_data_%0d got %h/%h exp %h/%h", round, r.rx, r.sl_rx, sb, dat[e]); else passes++;
        checks++; if (r.ss_and !== exp_ss(sel[e]) || r.ss_low != ((sel[e] < NUM_SS) ? XFER : 0)) $display("[TB] FAIL rand_ss_%0d got %b/%0d exp %b/%0d", round, r.ss_and, r.ss_low, exp_ss(sel[e]), (sel[e] < NUM_SS) ? XFER : 0); else passes++;
        if (!ok) pending = 4'b0;
      end
      repeat (5) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_reset_abort();
    test_bad_sel();
    test_drop_req();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
